// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: 2-flop synchroniser per channel, shared sample
// prescaler, and per-channel qualification counters with registered edge pulses.

module debounce_lane #(
  parameter int   STABLE_COUNT = 4,
  parameter int   CW           = 2,
  parameter logic RESET_BIT    = 1'b0
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= RESET_BIT;
      s2   <= RESET_BIT;
      cnt  <= '0;
      dout <= RESET_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        // a single agreeing sample restarts qualification
        if (s2 == dout) begin
          cnt <= '0;
        end else if (cnt == CW'(STABLE_COUNT - 1)) begin
          dout <= s2;
          cnt  <= '0;
          rise <= s2;
          fall <= ~s2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

module debounce_multi #(
  parameter int               WIDTH        = 1,
  parameter int               SAMPLE_DIV   = 2,
  parameter int               STABLE_COUNT = 4,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] de_in,
  output logic [WIDTH-1:0] de_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);
  localparam int PW = (SAMPLE_DIV   > 1) ? $clog2(SAMPLE_DIV)   : 1;
  localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;

  logic [PW-1:0] pcnt;

  // tick is registered off the wrap; with SAMPLE_DIV=1 it stays high after reset
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (pcnt == PW'(SAMPLE_DIV - 1)) begin
      pcnt <= '0;
      tick <= 1'b1;
    end else begin
      pcnt <= pcnt + PW'(1);
      tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    debounce_lane #(
      .STABLE_COUNT(STABLE_COUNT),
      .CW          (CW),
      .RESET_BIT   (RESET_VAL[i])
    ) u_lane (
      .mclk (mclk),
      .rst_n(rst_n),
      .tick (tick),
      .din  (de_in[i]),
      .dout (de_out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end
endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (fast 8-channel, prescaled 4-channel)
// checked by directed scenarios and a sample-window reference model.

module tb_debounce_multi;
  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  int errors = 0;
  int checks = 0;

  // A: WIDTH=8, SAMPLE_DIV=1, STABLE_COUNT=4, RESET_VAL=8'h0A
  logic       rst_a;
  logic [7:0] din_a, out_a, rise_a, fall_a;
  logic       tick_a;
  // B: WIDTH=4, SAMPLE_DIV=8, STABLE_COUNT=3, RESET_VAL=4'b1010
  logic       rst_b;
  logic [3:0] din_b, out_b, rise_b, fall_b;
  logic       tick_b;

  debounce_multi #(.WIDTH(8), .SAMPLE_DIV(1), .STABLE_COUNT(4), .RESET_VAL(8'h0A)) dut_a (
    .mclk(mclk), .rst_n(rst_a), .de_in(din_a), .de_out(out_a),
    .rise(rise_a), .fall(fall_a), .tick(tick_a));

  debounce_multi #(.WIDTH(4), .SAMPLE_DIV(8), .STABLE_COUNT(3), .RESET_VAL(4'b1010)) dut_b (
    .mclk(mclk), .rst_n(rst_b), .de_in(din_b), .de_out(out_b),
    .rise(rise_b), .fall(fall_b), .tick(tick_b));

  // Reference model: each channel keeps the window of samples taken since its
  // last output change; the output flips once the last N samples all disagree.
  logic [7:0] m_s1[2], m_s2[2], m_out[2], m_rise[2], m_fall[2];
  bit         m_tick[2];
  int         m_e[2];
  bit         smp[2][8][$];

  task automatic model_step(input int m, input logic rst, input logic [7:0] din,
                            input int d, input int n, input int w, input logic [7:0] rv);
    logic [7:0] samp;
    bit         t;
    bit         all_diff;
    if (!rst) begin
      m_s1[m] = rv; m_s2[m] = rv; m_out[m] = rv;
      m_rise[m] = '0; m_fall[m] = '0; m_tick[m] = 1'b0; m_e[m] = 0;
      for (int ch = 0; ch < 8; ch++) smp[m][ch].delete();
    end else begin
      samp = m_s2[m];
      t    = m_tick[m];
      m_rise[m] = '0;
      m_fall[m] = '0;
      if (t) begin
        for (int ch = 0; ch < w; ch++) begin
          smp[m][ch].push_back(samp[ch]);
          if (smp[m][ch].size() > n) void'(smp[m][ch].pop_front());
          if (smp[m][ch].size() == n) begin
            all_diff = 1'b1;
            for (int j = 0; j < n; j++)
              if (smp[m][ch][j] == m_out[m][ch]) all_diff = 1'b0;
            if (all_diff) begin
              m_out[m][ch] = ~m_out[m][ch];
              if (m_out[m][ch]) m_rise[m][ch] = 1'b1;
              else              m_fall[m][ch] = 1'b1;
              smp[m][ch].delete();
            end
          end
        end
      end
      m_s2[m]   = m_s1[m];
      m_s1[m]   = din;
      m_e[m]    = m_e[m] + 1;
      m_tick[m] = (m_e[m] % d) == 0;
    end
  endtask

  always @(posedge mclk or negedge rst_a) model_step(0, rst_a, din_a, 1, 4, 8, 8'h0A);
  always @(posedge mclk or negedge rst_b) model_step(1, rst_b, {4'b0, din_b}, 8, 3, 4, 8'h0A);

  task test_reset;
    repeat (10) begin
      @(negedge mclk);
      din_a = 8'($urandom);
      din_b = 4'($urandom);
      checks++;
      if (out_b !== 4'b1010 || rise_b !== 4'b0 || fall_b !== 4'b0 || tick_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_b: out=%b rise=%b fall=%b tick=%b, want 1010/0000/0000/0",
                 out_b, rise_b, fall_b, tick_b);
      end
      checks++;
      if (out_a !== 8'h0A || rise_a !== 8'h00 || fall_a !== 8'h00 || tick_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_a: out=%h rise=%h fall=%h tick=%b, want 0a/00/00/0",
                 out_a, rise_a, fall_a, tick_a);
      end
    end
    @(negedge mclk);
    din_a = 8'h0A; din_b = 4'b1010;
    rst_a = 1'b1;  rst_b = 1'b1;
    repeat (100) begin
      @(negedge mclk);
      checks++;
      if (out_b !== 4'b1010 || rise_b !== 4'b0 || fall_b !== 4'b0) begin
        errors++;
        $display("FAIL reset_release_b: out=%b rise=%b fall=%b, want 1010 no pulses",
                 out_b, rise_b, fall_b);
      end
      checks++;
      if (out_a !== 8'h0A || rise_a !== 8'h00 || fall_a !== 8'h00) begin
        errors++;
        $display("FAIL reset_release_a: out=%h rise=%h fall=%h, want 0a no pulses",
                 out_a, rise_a, fall_a);
      end
    end
  endtask

  task test_clean_edge;
    @(negedge mclk);
    din_a[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge mclk); @(negedge mclk);
      checks++;
      if (out_a[0] !== (k >= 5) || rise_a[0] !== (k == 5) || fall_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL clean_rise edge%0d: out=%b rise=%b fall=%b, want out=%b rise=%b fall=0",
                 k, out_a[0], rise_a[0], fall_a[0], k >= 5, k == 5);
      end
    end
    @(negedge mclk);
    din_a[0] = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge mclk); @(negedge mclk);
      checks++;
      if (out_a[0] !== (k < 5) || fall_a[0] !== (k == 5) || rise_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL clean_fall edge%0d: out=%b fall=%b rise=%b, want out=%b fall=%b rise=0",
                 k, out_a[0], fall_a[0], rise_a[0], k < 5, k == 5);
      end
    end
  endtask

  task test_glitch;
    int nr, nf;
    @(negedge mclk);
    din_a[0] = 1'b1;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    din_a[0] = 1'b0;
    repeat (12) begin
      @(negedge mclk);
      checks++;
      if (out_a[0] !== 1'b0 || rise_a[0] !== 1'b0 || fall_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch3: out=%b rise=%b fall=%b, want 0/0/0", out_a[0], rise_a[0], fall_a[0]);
      end
    end
    nr = 0; nf = 0;
    din_a[0] = 1'b1;
    repeat (4) @(posedge mclk);
    @(negedge mclk);
    din_a[0] = 1'b0;
    repeat (25) begin
      @(negedge mclk);
      nr += int'(rise_a[0]);
      nf += int'(fall_a[0]);
    end
    checks++;
    if (nr != 1 || nf != 1 || out_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch4: rises=%0d falls=%0d out=%b, want 1/1/0", nr, nf, out_a[0]);
    end
  endtask

  task test_prescaled;
    int n, lat;
    n = 0;
    @(negedge mclk);
    while (!tick_b && n < 20) begin @(negedge mclk); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL tick_found: no tick within 20 cycles, want one"); end
    repeat (3) begin
      n = 0;
      do begin @(negedge mclk); n++; end while (!tick_b && n < 20);
      checks++;
      if (n != 8) begin errors++; $display("FAIL tick_period: got %0d cycles, want 8", n); end
    end
    repeat ($urandom_range(0, 7)) @(negedge mclk);
    din_b[0] = 1'b1;
    lat = -1;
    for (int k = 0; k <= 30; k++) begin
      @(posedge mclk); @(negedge mclk);
      checks++;
      if (out_b !== m_out[1][3:0] || rise_b !== m_rise[1][3:0] || tick_b !== m_tick[1]) begin
        errors++;
        $display("FAIL presc_model edge%0d: out=%b rise=%b tick=%b, want %b %b %b",
                 k, out_b, rise_b, tick_b, m_out[1][3:0], m_rise[1][3:0], m_tick[1]);
      end
      if (out_b[0] === 1'b1 && lat < 0) lat = k;
    end
    checks++;
    if (lat < 18 || lat > 26) begin
      errors++;
      $display("FAIL presc_latency: changed after edge %0d, want 18..26", lat);
    end
    din_b[0] = 1'b0;
    repeat (40) @(negedge mclk);
  endtask

  task test_multi;
    int c0, c7, n0, n7, bad3;
    logic [7:0] other;
    @(negedge mclk);
    din_a = 8'h0A;
    repeat (20) @(negedge mclk);
    din_a[0] = 1'b1; din_a[7] = 1'b1; din_a[3] = 1'b0;
    c0 = -1; c7 = -1; n0 = 0; n7 = 0; bad3 = 0; other = '0;
    for (int k = 0; k < 16; k++) begin
      @(posedge mclk); @(negedge mclk);
      if (k == 1) din_a[3] = 1'b1;
      if (rise_a[0]) begin n0++; c0 = k; end
      if (rise_a[7]) begin n7++; c7 = k; end
      other |= (rise_a | fall_a) & 8'h7E;
      if (out_a[3] !== 1'b1) bad3++;
    end
    checks++;
    if (c0 != 5 || c7 != 5 || n0 != 1 || n7 != 1) begin
      errors++;
      $display("FAIL multi_same_cycle: ch0 at %0d x%0d, ch7 at %0d x%0d, want both at 5 x1",
               c0, n0, c7, n7);
    end
    checks++;
    if (other !== 8'h00 || bad3 != 0) begin
      errors++;
      $display("FAIL multi_silent: other pulses=%b ch3 low cycles=%0d, want 0/0", other, bad3);
    end
  endtask

  task test_reset_mid;
    @(negedge mclk);
    din_a = 8'h0A;
    repeat (20) @(negedge mclk);
    din_a[0] = 1'b1;
    repeat (4) @(posedge mclk);
    @(negedge mclk);
    rst_a = 1'b0;
    #1;
    checks++;
    if (out_a !== 8'h0A || rise_a !== 8'h00 || fall_a !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: out=%h rise=%h fall=%h, want 0a/00/00", out_a, rise_a, fall_a);
    end
    repeat (3) @(negedge mclk);
    rst_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge mclk); @(negedge mclk);
      checks++;
      if (out_a[0] !== (k >= 6) || rise_a[0] !== (k == 6)) begin
        errors++;
        $display("FAIL reset_requal edge%0d: out=%b rise=%b, want %b %b",
                 k, out_a[0], rise_a[0], k >= 6, k == 6);
      end
    end
  endtask

  task test_random;
    logic [7:0] pr_a, pf_a;
    pr_a = '0; pf_a = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge mclk);
      checks++;
      if (out_a !== m_out[0] || rise_a !== m_rise[0] || fall_a !== m_fall[0] || tick_a !== m_tick[0]) begin
        errors++;
        $display("FAIL rand_a cyc%0d: out=%h rise=%h fall=%h tick=%b, want %h %h %h %b",
                 c, out_a, rise_a, fall_a, tick_a, m_out[0], m_rise[0], m_fall[0], m_tick[0]);
      end
      checks++;
      if (out_b !== m_out[1][3:0] || rise_b !== m_rise[1][3:0] || fall_b !== m_fall[1][3:0] ||
          tick_b !== m_tick[1]) begin
        errors++;
        $display("FAIL rand_b cyc%0d: out=%b rise=%b fall=%b tick=%b, want %b %b %b %b",
                 c, out_b, rise_b, fall_b, tick_b,
                 m_out[1][3:0], m_rise[1][3:0], m_fall[1][3:0], m_tick[1]);
      end
      checks++;
      if ((rise_a & fall_a) !== 8'h00 || (rise_a & pr_a) !== 8'h00 || (fall_a & pf_a) !== 8'h00) begin
        errors++;
        $display("FAIL rand_pulse_rules cyc%0d: rise=%h fall=%h prev %h %h, want disjoint single-cycle",
                 c, rise_a, fall_a, pr_a, pf_a);
      end
      pr_a = rise_a; pf_a = fall_a;
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 5) == 0) din_a[i] = ~din_a[i];
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 39) == 0) din_b[i] = ~din_b[i];
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    din_a = '0;   din_b = '0;
    test_reset;
    test_clean_edge;
    test_glitch;
    test_prescaled;
    test_multi;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel debouncer for mechanical switches, IR/echo lines and button inputs feeding the car-control IPs.
- Each input is synchronised into the mclk domain and sampled on a shared prescaled tick.
- The output of a channel toggles only after its input has differed from the output for STABLE_COUNT consecutive ticks.
- Per-channel one-clock rise/fall pulses are provided, so downstream FSMs need no edge detectors.

Parameters:
WIDTH, 1, number of independent channels (>=1)
SAMPLE_DIV, 2, mclk cycles per sample tick (>=1; 1 = tick every cycle)
STABLE_COUNT, 4, consecutive mismatching ticks required before the output changes (>=1)
RESET_VAL, 0, WIDTH-bit value loaded into the synchronisers and de_out at reset

Ports:
mclk  input  1  system clock, all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
de_in  input  WIDTH  raw asynchronous inputs
de_out  output  WIDTH  debounced level per channel
rise  output  WIDTH  1-cycle pulse when de_out[i] goes 0->1
fall  output  WIDTH  1-cycle pulse when de_out[i] goes 1->0
tick  output  1  sample strobe, exported for sharing and verification

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both synchroniser stages and de_out = RESET_VAL; rise = fall = 0; tick = 0.
  - Prescaler counter and all channel counters = 0.
  - Reset deassertion takes effect at the next mclk edge. No edge pulse is ever generated by reset entry or exit.
- Synchroniser: 2-flop chain per channel; sync[i] = de_in[i] delayed 2 mclk.
- Prescaler:
  - Width max(1, clog2(SAMPLE_DIV)). Counts 0..SAMPLE_DIV-1 and wraps.
  - tick is registered, high for exactly 1 cycle when the counter wraps. Period = SAMPLE_DIV cycles.
  - SAMPLE_DIV = 1: tick is held high continuously from the first edge after reset.
- Channel counter: cnt[i], width max(1, clog2(STABLE_COUNT)), updated only in tick cycles:
  - sync[i] == de_out[i]: cnt[i] <= 0. Any single agreeing sample restarts qualification.
  - sync[i] != de_out[i] and cnt[i] < STABLE_COUNT-1: cnt[i] <= cnt[i]+1.
  - sync[i] != de_out[i] and cnt[i] == STABLE_COUNT-1: de_out[i] <= sync[i]; cnt[i] <= 0; rise[i] or fall[i] asserted in the same cycle de_out[i] changes.
  - Non-tick cycles: cnt and de_out hold; rise = fall = 0.
- Pulse rules:
  - rise/fall are registered, never both high on one channel, and never high for two consecutive cycles.
  - Several channels may pulse in the same cycle.
- Latency:
  - SAMPLE_DIV = 1: de_out changes at mclk edge N+2 after the input settles, with N = STABLE_COUNT. Example: input stable before edge 0, N = 4 -> output changes after edge 5.
  - General case: output changes 2 + (ticks needed) cycles after the input settles, bounded by 2 + SAMPLE_DIV*STABLE_COUNT cycles.
- Glitches: pulses shorter than the tick period may go unsampled. A glitch that is sampled but lasts fewer than STABLE_COUNT ticks leaves de_out unchanged.
- Channels are fully independent and share only the tick.
- Reset mid-qualification: all partial counts are discarded and de_out returns to RESET_VAL immediately, asynchronously.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=4'b1010, hold rst_n low with de_in toggling -> de_out=4'b1010, rise=fall=0. Release with de_in=4'b1010 -> no pulses for 100 cycles.
- Clean edge: SAMPLE_DIV=1, STABLE_COUNT=4. de_in[0] 0->1 before edge 0 -> de_out[0]=1 and rise[0]=1 after edge 5 only. rise[0] low at edge 6. Same check for the 1->0 transition with fall[0].
- Glitch rejection: SAMPLE_DIV=1, STABLE_COUNT=4. Hold de_in[0]=1 for 3 cycles then 0 -> de_out[0] stays 0 with no pulse. A 4-cycle pulse -> exactly one rise then one fall.
- Prescaled sampling: SAMPLE_DIV=8, STABLE_COUNT=3 -> tick period exactly 8 cycles. A step input changes de_out within 2+24 cycles and never before the 3rd tick after the sync delay.
- Multi-channel independence: WIDTH=8. Step channels 0 and 7 together, bounce channel 3 for 2 ticks -> de_out[0] and de_out[7] rise in the same cycle, channel 3 unchanged, other channels silent.
- Reset mid-operation: assert rst_n after 2 of 4 qualifying ticks, release with the input still changed -> a full STABLE_COUNT is requalified and the output changes 6 cycles after release (SAMPLE_DIV=1).
